iter_divider: RTL and testbench



---
 rtl/iter_divider.sv | 142 ++++++++++++++
 tb/tb_iter_divider.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero and signed-overflow flags packed alongside the result.
module iter_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   inputP,
  input  logic [WIDTH-1:0]   inputQ,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               overflow,
  output logic [1:0]         o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: start is sampled only in IDLE; busy covers every non-IDLE cycle
  // and done marks the single cycle in which result and flags are fresh.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_ovf;

  logic             w_p_neg;
  logic             w_q_neg;
  logic [WIDTH-1:0] w_p_abs;
  logic [WIDTH-1:0] w_q_abs;
  logic             w_q_zero;
  logic             w_ovf_in;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_p_neg  = signed_mode & inputP[WIDTH-1];
  assign w_q_neg  = signed_mode & inputQ[WIDTH-1];
  assign w_p_abs  = w_p_neg ? (~inputP + ONE) : inputP;
  assign w_q_abs  = w_q_neg ? (~inputQ + ONE) : inputQ;
  assign w_q_zero = (inputQ == '0);
  assign w_ovf_in = signed_mode & (inputP == MOST_NEG) & (inputQ == '1);

  // Partial remainder stays below the divisor, so the shifted trial never
  // reaches the top bit and a set top bit of the difference means "borrow".
  assign w_trial = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_trial - {2'b00, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH+1];

  assign w_quo_fix = r_q_neg ? (~r_dvd + ONE) : r_dvd;
  assign w_rem_fix = r_r_neg ? (~r_rem[WIDTH-1:0] + ONE) : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_q_zero ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_ovf       <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= w_p_abs;
            r_dvs   <= w_q_abs;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH-1);
            r_q_neg <= w_p_neg ^ w_q_neg;
            r_r_neg <= w_p_neg;
            r_ovf   <= w_ovf_in;
            // Zero divisor skips the iteration and publishes immediately.
            if (w_q_zero) begin
              result      <= {inputP, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_qbit ? w_diff[WIDTH:0] : w_trial[WIDTH:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          result      <= {w_rem_fix, w_quo_fix};
          div_by_zero <= 1'b0;
          overflow    <= r_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed table, handshake corner
// sequences and randomized operations scored against an arithmetic model.
module tb_iter_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] inputP = '0;
  logic [W-1:0] inputQ = '0;
  logic         busy;
  logic         done;
  logic [2*W-1:0] result;
  logic         div_by_zero;
  logic         overflow;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Scoreboard entries: {result, div_by_zero, overflow}
  logic [2*W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   p;
    logic [W-1:0]   q;
    logic           sm;
    logic [2*W-1:0] res;
    logic           dz;
    logic           ov;
    int             lat;
  } vec_t;

  vec_t vecs[12];

  iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inputP      (inputP),
    .inputQ      (inputQ),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] p, input logic [W-1:0] q,
                                             input logic sm);
    int sp, sq, qq, rr;
    logic [W-1:0] qo, ro;
    if (q == '0) return {p, {W{1'b1}}, 2'b10};
    if (!sm) begin
      qo = p / q;
      ro = p % q;
      return {ro, qo, 2'b00};
    end
    sp = int'($signed(p));
    sq = int'($signed(q));
    qq = sp / sq;
    rr = sp % sq;
    qo = qq[W-1:0];
    ro = rr[W-1:0];
    return {ro, qo, 1'b0, (sp == -(2**(W-1)) && sq == -1)};
  endfunction

  // Issues one start, checks busy each cycle, returns outputs seen with done
  // and the done cycle (cycle 0 = acceptance cycle; -1 on timeout).
  task automatic run_op(input logic [W-1:0] p, input logic [W-1:0] q, input logic sm,
                        input int pulse_at, input logic [W-1:0] pp, input logic [W-1:0] pq,
                        output logic [2*W+1:0] got, output int lat);
    lat = -1;
    got = '0;
    @(negedge clk);
    inputP = p; inputQ = q; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    inputP = W'($urandom); inputQ = W'($urandom); signed_mode = 1'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", c), busy, 1);
      if (done) begin
        lat = c;
        got = {result, div_by_zero, overflow};
        break;
      end
      if (c == pulse_at) begin
        inputP = pp; inputQ = pq; signed_mode = ~sm; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (lat < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    logic [2*W+1:0] got, e;
    int lat, d0;
    logic [W-1:0] rp, rq;
    logic rs;

    vecs[0]  = '{16'd100,  16'd7,    1'b0, 32'h0002000E, 1'b0, 1'b0, 18};
    vecs[1]  = '{16'hFFF9, 16'h0002, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 18};
    vecs[2]  = '{16'h0007, 16'hFFFE, 1'b1, 32'h0001FFFD, 1'b0, 1'b0, 18};
    vecs[3]  = '{16'd1234, 16'd0,    1'b0, 32'h04D2FFFF, 1'b1, 1'b0, 1};
    vecs[4]  = '{16'd9,    16'd3,    1'b0, 32'h00000003, 1'b0, 1'b0, 18};
    vecs[5]  = '{16'h8000, 16'hFFFF, 1'b1, 32'h00008000, 1'b0, 1'b1, 18};
    vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 32'h80000000, 1'b0, 1'b0, 18};
    vecs[7]  = '{16'd5,    16'd9,    1'b0, 32'h00050000, 1'b0, 1'b0, 18};
    vecs[8]  = '{16'hFF9C, 16'hFFF9, 1'b1, 32'hFFFE000E, 1'b0, 1'b0, 18};
    vecs[9]  = '{16'hFFF9, 16'h0000, 1'b1, 32'hFFF9FFFF, 1'b1, 1'b0, 1};
    vecs[10] = '{16'h0000, 16'd5,    1'b1, 32'h00000000, 1'b0, 1'b0, 18};
    vecs[11] = '{16'hFFFF, 16'd1,    1'b0, 32'h0000FFFF, 1'b0, 1'b0, 18};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].p, vecs[i].q, vecs[i].sm, 0, '0, '0, got, lat);
      check($sformatf("v%0d_result", i), got[2*W+1:2], vecs[i].res);
      check($sformatf("v%0d_dz", i), got[1], vecs[i].dz);
      check($sformatf("v%0d_ov", i), got[0], vecs[i].ov);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    end

    // Outputs hold in IDLE until the next completion
    repeat (3) @(negedge clk);
    check("hold_result", result, 32'h0000FFFF);
    check("hold_dz", div_by_zero, 0);

    // Start while busy is ignored; exactly one done pulse
    d0 = done_cnt;
    run_op(16'd100, 16'd7, 1'b0, 5, 16'd50, 16'd5, got, lat);
    check("ign_result", got[2*W+1:2], 32'h0002000E);
    check("ign_latency", lat, 18);
    repeat (4) @(negedge clk);
    check("ign_done_count", done_cnt - d0, 1);

    // Asynchronous reset in cycle 8 of 65535 / 1
    @(negedge clk);
    inputP = 16'hFFFF; inputQ = 16'd1; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_done", done, 0);
    check("arst_state", dbg_state, 0);
    #3;
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_result_after", result, 0);
    run_op(16'hFFFF, 16'd1, 1'b0, 0, '0, '0, got, lat);
    check("arst_next_result", got[2*W+1:2], 32'h0000FFFF);
    check("arst_next_latency", lat, 18);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom);
      case ($urandom_range(0, 4))
        0: rq = '0;
        1: rq = W'($urandom_range(1, 15));
        2: rq = '1;
        default: rq = W'($urandom);
      endcase
      rp = ($urandom_range(0, 5) == 0) ? 16'h8000 : W'($urandom);
      exp_q.push_back(ref_div(rp, rq, rs));
      run_op(rp, rq, rs, 0, '0, '0, got, lat);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_p%h_q%h_s%0d", n, rp, rq, rs), got, e);
      check($sformatf("rnd%0d_latency", n), lat, (rq == '0) ? 1 : 18);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
